// File: rtl/spi_flash_init_master.sv
// rtl/spi_flash_init_master.sv - boot-time SPI master that switches the program flash into quad mode
module spi_flash_init_master #(
    parameter int unsigned CLK_DIV  = 2,
    parameter logic [15:0] SR_VALUE = 16'h0002,
    parameter int unsigned CS_GAP   = 4,
    parameter int unsigned MAX_POLL = 1024
) (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] status,
    output logic       spi_sclk,
    output logic       spi_cs_n,
    output logic       spi_io0,
    input  logic       spi_io1,
    output logic       spi_io2,
    output logic       spi_io3
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam int PW = $clog2(MAX_POLL + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
    localparam logic [PW-1:0] POLL_MAX = PW'(MAX_POLL);

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_WREN, S_WRSR, S_RDSR, S_FIN, S_ERR
    } state_t;

    state_t        state_q, state_d, nxt_q, nxt_d;
    logic          busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [7:0]    status_q, status_d;
    logic          sclk_q, sclk_d, cs_n_q, cs_n_d, io0_q, io0_d;
    logic [23:0]   sh_q, sh_d;
    logic [6:0]    rx_q, rx_d;
    logic [DW-1:0] div_q, div_d;
    logic [4:0]    bit_q, bit_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [PW-1:0] poll_q, poll_d;

    logic [23:0]   load_word;
    logic [4:0]    bit_last;
    logic [7:0]    rd_byte;
    logic [PW-1:0] poll_inc;

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign status   = status_q;
    assign spi_sclk = sclk_q;
    assign spi_cs_n = cs_n_q;
    assign spi_io0  = io0_q;
    assign spi_io2  = 1'b1;
    assign spi_io3  = 1'b1;

    // Shift word for the frame about to be launched and bit count of the frame in flight
    always_comb begin
        load_word = {8'h06, 16'h0000};
        bit_last  = 5'd15;
        case (nxt_q)
            S_WRSR:  load_word = {8'h01, SR_VALUE};
            S_RDSR:  load_word = {8'h05, 16'h0000};
            default: load_word = {8'h06, 16'h0000};
        endcase
        case (state_q)
            S_WREN:  bit_last = 5'd7;
            S_WRSR:  bit_last = 5'd23;
            default: bit_last = 5'd15;
        endcase
    end

    // Sequence control: launches frames, paces SCLK, shifts io0/io1 and judges the status byte
    always_comb begin
        state_d  = state_q;
        nxt_d    = nxt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        error_d  = error_q;
        status_d = status_q;
        sclk_d   = sclk_q;
        cs_n_d   = cs_n_q;
        io0_d    = io0_q;
        sh_d     = sh_q;
        rx_d     = rx_q;
        div_d    = div_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
        poll_d   = poll_q;
        rd_byte  = {rx_q, spi_io1};
        poll_inc = poll_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    poll_d  = '0;
                    gap_d   = GAP_LAST;  // launch WREN on the very next edge
                    nxt_d   = S_WREN;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    io0_d   = load_word[23];
                    sh_d    = {load_word[22:0], 1'b0};
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = nxt_q;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_WREN, S_WRSR, S_RDSR: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (state_q == S_RDSR && bit_q[3]) begin
                            rx_d = {rx_q[5:0], spi_io1};
                        end
                        if (bit_q != bit_last) begin
                            bit_d = bit_q + 1'b1;
                            io0_d = sh_q[23];
                            sh_d  = {sh_q[22:0], 1'b0};
                        end else begin
                            cs_n_d = 1'b1;
                            io0_d  = 1'b0;
                            gap_d  = '0;
                            case (state_q)
                                S_WREN: begin
                                    nxt_d   = S_WRSR;
                                    state_d = S_GAP;
                                end
                                S_WRSR: begin
                                    nxt_d   = S_RDSR;
                                    state_d = S_GAP;
                                end
                                default: begin
                                    status_d = rd_byte;
                                    if (!rd_byte[0]) begin
                                        state_d = S_FIN;
                                    end else begin
                                        poll_d = poll_inc;
                                        if (poll_inc == POLL_MAX) begin
                                            state_d = S_ERR;
                                        end else begin
                                            nxt_d   = S_RDSR;
                                            state_d = S_GAP;
                                        end
                                    end
                                end
                            endcase
                        end
                    end
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_ERR: begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset forces the pins idle even mid-frame
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q  <= S_IDLE;
            nxt_q    <= S_WREN;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            status_q <= 8'h00;
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            io0_q    <= 1'b0;
            sh_q     <= '0;
            rx_q     <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            gap_q    <= '0;
            poll_q   <= '0;
        end else begin
            state_q  <= state_d;
            nxt_q    <= nxt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            status_q <= status_d;
            sclk_q   <= sclk_d;
            cs_n_q   <= cs_n_d;
            io0_q    <= io0_d;
            sh_q     <= sh_d;
            rx_q     <= rx_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            gap_q    <= gap_d;
            poll_q   <= poll_d;
        end
    end

endmodule
